// File: rtl/bcd_serial_accumulator.sv
// Digit-serial packed-BCD adder sequencer driving an external one-digit BCD adder cell, LSD first.
// Optional macro BCD_ACC_CHAIN_EN adds an accumulate input that reuses the last result as operand A.
module bcd_serial_accumulator #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   opA,
    input  logic [4*DIGITS-1:0]   opB,
    input  logic                  carryIn,
`ifdef BCD_ACC_CHAIN_EN
    input  logic                  accumulate,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  carryOut,
    output logic                  sumVal,
    output logic [3:0]            adderA,
    output logic [3:0]            adderB,
    output logic                  adderCin,
    input  logic [3:0]            adderSum,
    input  logic                  adderCout,
    input  logic                  adderVal
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_opa;
    logic [W-1:0]   r_opb;
    logic [W-1:0]   r_res;
    logic [CW-1:0]  r_idx;
    logic           r_carry;
    logic           r_val;

    logic           w_last;
    logic [W-1:0]   w_res_shift;
    logic [W-1:0]   w_opa_init;
    logic           w_cin_init;

    assign w_last      = (r_idx == CW'(DIGITS - 1));
    assign w_res_shift = W'({adderSum, r_res} >> 4);

`ifdef BCD_ACC_CHAIN_EN
    assign w_opa_init = accumulate ? result : opA;
    assign w_cin_init = accumulate ? 1'b0 : carryIn;
`else
    assign w_opa_init = opA;
    assign w_cin_init = carryIn;
`endif

    // Operand registers shift in zeros and the carry is cleared on exit, so these idle at 0.
    assign adderA   = r_opa[3:0];
    assign adderB   = r_opb[3:0];
    assign adderCin = r_carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carryOut <= 1'b0;
            sumVal   <= 1'b1;
            r_opa    <= '0;
            r_opb    <= '0;
            r_res    <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_val    <= 1'b1;
        end else begin
            busy <= (w_next == S_RUN);
            done <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opa   <= w_opa_init;
                        r_opb   <= opB;
                        r_carry <= w_cin_init;
                        r_val   <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                S_RUN: begin
                    r_opa <= r_opa >> 4;
                    r_opb <= r_opb >> 4;
                    r_idx <= r_idx + CW'(1);
                    // Final digit goes straight to the outputs along with its carry and validity.
                    if (w_last) begin
                        result   <= w_res_shift;
                        carryOut <= adderCout;
                        sumVal   <= r_val & adderVal;
                        r_res    <= w_res_shift;
                        r_carry  <= 1'b0;
                        r_val    <= 1'b1;
                    end else begin
                        r_res   <= w_res_shift;
                        r_carry <= adderCout;
                        r_val   <= r_val & adderVal;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_accumulator.sv
// Scoreboard bench for bcd_serial_accumulator with a behavioural one-digit BCD adder cell.
module tb_bcd_serial_accumulator;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   opA;
    logic [W-1:0]   opB;
    logic           carryIn;
    logic           accumulate;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           carryOut;
    logic           sumVal;
    logic [3:0]     adderA;
    logic [3:0]     adderB;
    logic           adderCin;
    logic [3:0]     adderSum;
    logic           adderCout;
    logic           adderVal;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_exp  = 0;
    int n_before;
    logic [W+1:0] sb_q[$];
    logic [W+1:0] sb_e;
    logic [5:0]   add_tmp;

    bcd_serial_accumulator #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opA       (opA),
        .opB       (opB),
        .carryIn   (carryIn),
`ifdef BCD_ACC_CHAIN_EN
        .accumulate(accumulate),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carryOut  (carryOut),
        .sumVal    (sumVal),
        .adderA    (adderA),
        .adderB    (adderB),
        .adderCin  (adderCin),
        .adderSum  (adderSum),
        .adderCout (adderCout),
        .adderVal  (adderVal)
    );

    always #5 clk = ~clk;

    // Reference single-digit BCD adder cell.
    always_comb begin
        add_tmp = 6'(adderA) + 6'(adderB) + 6'(adderCin);
        if (add_tmp > 6'd9) begin
            adderSum  = 4'(add_tmp + 6'd6);
            adderCout = 1'b1;
        end else begin
            adderSum  = 4'(add_tmp);
            adderCout = 1'b0;
        end
        adderVal = (adderA <= 4'd9) && (adderB <= 4'd9);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse consumes one expected response.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
            end else begin
                sb_e = sb_q.pop_front();
                chk("result",   32'(result),   32'(sb_e[W+1:2]));
                chk("carryOut", 32'(carryOut), 32'(sb_e[1]));
                chk("sumVal",   32'(sumVal),   32'(sb_e[0]));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic acc, input logic [W-1:0] er, input logic ec, input logic ev);
        @(negedge clk);
        opA        = a;
        opB        = b;
        carryIn    = cin;
        accumulate = acc;
        start      = 1'b1;
        sb_q.push_back({er, ec, ev});
        n_exp++;
        @(negedge clk);
        start      = 1'b0;
        opA        = W'($urandom);
        opB        = W'($urandom);
        carryIn    = 1'b1;
        accumulate = 1'b0;
        repeat (DIGITS) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        opA        = 16'h9999;
        opB        = 16'h9999;
        carryIn    = 1'b1;
        accumulate = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_result",   32'(result),   32'd0);
        chk("rst_carryOut", 32'(carryOut), 32'd0);
        chk("rst_sumVal",   32'(sumVal),   32'd1);
        chk("rst_adderA",   32'(adderA),   32'd0);
        chk("rst_adderCin", 32'(adderCin), 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        // Basic add with cycle-by-cycle timing and adder port checks.
        @(negedge clk);
        opA = 16'h1234; opB = 16'h5678; carryIn = 1'b0; start = 1'b1;
        sb_q.push_back({16'h6912, 1'b0, 1'b1});
        n_exp++;
        @(negedge clk);
        start = 1'b0;
        chk("t1_busy1",  32'(busy),     32'd1);
        chk("t1_adA1",   32'(adderA),   32'h4);
        chk("t1_adB1",   32'(adderB),   32'h8);
        chk("t1_cin1",   32'(adderCin), 32'd0);
        @(negedge clk);
        chk("t1_busy2",  32'(busy),     32'd1);
        chk("t1_adA2",   32'(adderA),   32'h3);
        chk("t1_adB2",   32'(adderB),   32'h7);
        chk("t1_cin2",   32'(adderCin), 32'd1);
        repeat (2) begin
            @(negedge clk);
            chk("t1_busy34", 32'(busy), 32'd1);
            chk("t1_done34", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("t1_done5",  32'(done), 32'd1);
        chk("t1_busy5",  32'(busy), 32'd0);
        @(negedge clk);
        chk("t1_done6",  32'(done),     32'd0);
        chk("t1_idleA",  32'(adderA),   32'd0);
        chk("t1_idleC",  32'(adderCin), 32'd0);
        chk("t1_hold",   32'(result),   32'h6912);

        // Full carry ripple, both via operand and via carryIn.
        issue(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        issue(16'h9999, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Invalid digit then a clean add restores validity.
        issue(16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h1305, 1'b0, 1'b0);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b1);

        // Start re-pulsed while busy is ignored.
        @(negedge clk);
        opA = 16'h0011; opB = 16'h0022; carryIn = 1'b0; start = 1'b1;
        sb_q.push_back({16'h0033, 1'b0, 1'b1});
        n_exp++;
        @(negedge clk);
        start = 1'b0; opA = 16'h5555; opB = 16'h4444;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // Reset mid-run aborts without a done pulse.
        n_before = n_done;
        @(negedge clk);
        opA = 16'h1111; opB = 16'h1111; carryIn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",     32'(busy),     32'd0);
        chk("abort_done",     32'(done),     32'd0);
        chk("abort_result",   32'(result),   32'd0);
        chk("abort_carryOut", 32'(carryOut), 32'd0);
        chk("abort_sumVal",   32'(sumVal),   32'd1);
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(n_done), 32'(n_before));
        issue(16'h0045, 16'h0055, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1);

        // Start held high back-to-back: two operations.
        @(negedge clk);
        opA = 16'h0005; opB = 16'h0005; carryIn = 1'b0; start = 1'b1;
        sb_q.push_back({16'h0010, 1'b0, 1'b1});
        sb_q.push_back({16'h0010, 1'b0, 1'b1});
        n_exp += 2;
        repeat (8) @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);

`ifdef BCD_ACC_CHAIN_EN
        issue(16'h0500, 16'h0250, 1'b0, 1'b0, 16'h0750, 1'b0, 1'b1);
        issue(16'h9999, 16'h0250, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b1);
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty",   32'(sb_q.size()), 32'd0);
        chk("done_count", 32'(n_done),      32'(n_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
